// File: rtl/bcd_field_editor.sv
// Multi-field two-digit BCD editor with cursor, per-field wrap and optional date-mode day clamping.
// Define BCD_FIELD_EDITOR_AUTOREPEAT_EN to add held-button auto-repeat on up/down.
module bcd_field_editor #(
    parameter int NUM_FIELDS = 3,
    parameter logic [8*NUM_FIELDS-1:0] FIELD_MIN = {8'h00, 8'h01, 8'h01},
    parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX = {8'h99, 8'h12, 8'h31},
    parameter int DATE_MODE    = 1,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [8*NUM_FIELDS-1:0] val_in,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    output logic [8*NUM_FIELDS-1:0] val_out,
    output logic [2:0]              cursor,
    output logic                    dirty,
    output logic                    ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_EDIT  = 2'd2;
    localparam logic [1:0] ST_CLAMP = 2'd3;
    localparam logic [2:0] LAST_FIELD = 3'(NUM_FIELDS - 1);

    if (NUM_FIELDS < 2 || NUM_FIELDS > 8 || (DATE_MODE != 0 && NUM_FIELDS < 3)
        || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("bcd_field_editor: illegal parameter combination");
    end

    function automatic logic [7:0] get_field(input logic [8*NUM_FIELDS-1:0] v, input logic [2:0] idx);
        logic [7:0] f;
        f = 8'h00;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (idx == 3'(i)) f = v[i*8 +: 8];
        end
        return f;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h9) r = {((v[7:4] == 4'h9) ? 4'h0 : v[7:4] + 4'h1), 4'h0};
        else                r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h0) r = {((v[7:4] == 4'h0) ? 4'h9 : v[7:4] - 4'h1), 4'h9};
        else                r = {v[7:4], v[3:0] - 4'h1};
        return r;
    endfunction

    // Year is 20YY; 2000 is a multiple of 4, so only YY decides leap years.
    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
        logic [6:0] yb;
        logic [7:0] d;
        yb = 7'(y[7:4]) * 7'd10 + 7'(y[3:0]);
        case (m)
            8'h02:                      d = (yb[1:0] == 2'b00) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

    logic [1:0]              state_r, state_n_s;
    logic [3:0]              prev_r, prev_n_s;
    logic [3:0]              levels_s, press_s;
    logic                    rep_up_s, rep_dn_s, up_ev_s, dn_ev_s;
    logic [7:0]              fld_s, fmin_s, fmax_s, new_fld_s, dim_s;
    logic [8*NUM_FIELDS-1:0] val_n_s;
    logic [2:0]              cursor_n_s;
    logic                    dirty_n_s;

    assign levels_s = {btn_right, btn_left, btn_down, btn_up};
    assign press_s  = levels_s & ~prev_r;
    assign dim_s    = days_in_month(get_field(val_out, 3'd1), get_field(val_out, 3'd2));

`ifdef BCD_FIELD_EDITOR_AUTOREPEAT_EN
    logic [31:0] rep_cnt_r;
    logic        rep_first_r;
    logic        rep_hold_s, rep_fire_s;

    assign rep_hold_s = en && (state_r == ST_EDIT) && (btn_up ^ btn_down);
    assign rep_fire_s = rep_hold_s && (rep_first_r ? (rep_cnt_r == 32'(REPEAT_DELAY - 1))
                                                   : (rep_cnt_r == 32'(REPEAT_RATE - 1)));
    assign rep_up_s   = rep_fire_s & btn_up;
    assign rep_dn_s   = rep_fire_s & btn_down;

    // Hold-time counter: first repeat after REPEAT_DELAY, then every REPEAT_RATE.
    always_ff @(posedge clk) begin
        if (reset || !rep_hold_s) begin
            rep_cnt_r   <= 32'd0;
            rep_first_r <= 1'b1;
        end else if (rep_fire_s) begin
            rep_cnt_r   <= 32'd0;
            rep_first_r <= 1'b0;
        end else begin
            rep_cnt_r   <= rep_cnt_r + 32'd1;
        end
    end
`else
    assign rep_up_s = 1'b0;
    assign rep_dn_s = 1'b0;
`endif

    // Up/down result for the field under the cursor, including wrap and out-of-range snap.
    always_comb begin
        up_ev_s = press_s[0] | rep_up_s;
        dn_ev_s = press_s[1] | rep_dn_s;
        fld_s   = get_field(val_out, cursor);
        fmin_s  = get_field(FIELD_MIN, cursor);
        fmax_s  = (DATE_MODE != 0 && cursor == 3'd0) ? dim_s : get_field(FIELD_MAX, cursor);
        if (up_ev_s && !dn_ev_s) begin
            new_fld_s = (fld_s == fmax_s || fld_s < fmin_s || fld_s > fmax_s) ? fmin_s : bcd_inc(fld_s);
        end else if (dn_ev_s && !up_ev_s) begin
            new_fld_s = (fld_s == fmin_s || fld_s < fmin_s || fld_s > fmax_s) ? fmax_s : bcd_dec(fld_s);
        end else begin
            new_fld_s = fld_s;
        end
    end

    // Next-state logic for the FSM, fields, cursor and button history.
    always_comb begin
        state_n_s  = state_r;
        val_n_s    = val_out;
        cursor_n_s = cursor;
        dirty_n_s  = dirty;
        prev_n_s   = prev_r;
        if (!en) begin
            state_n_s  = ST_IDLE;
            cursor_n_s = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: state_n_s = ST_LOAD;
                ST_LOAD: begin
                    val_n_s    = val_in;
                    dirty_n_s  = 1'b0;
                    cursor_n_s = 3'd0;
                    prev_n_s   = levels_s;
                    state_n_s  = ST_EDIT;
                end
                ST_EDIT: begin
                    prev_n_s = levels_s;
                    if (new_fld_s != fld_s) begin
                        for (int i = 0; i < NUM_FIELDS; i++) begin
                            if (cursor == 3'(i)) val_n_s[i*8 +: 8] = new_fld_s;
                            else                 val_n_s[i*8 +: 8] = val_out[i*8 +: 8];
                        end
                        dirty_n_s = 1'b1;
                        if (DATE_MODE != 0 && (cursor == 3'd1 || cursor == 3'd2)) state_n_s = ST_CLAMP;
                        else                                                       state_n_s = ST_EDIT;
                    end else begin
                        state_n_s = ST_EDIT;
                    end
                    if (press_s[3] && !press_s[2]) begin
                        cursor_n_s = (cursor == LAST_FIELD) ? 3'd0 : cursor + 3'd1;
                    end else if (press_s[2] && !press_s[3]) begin
                        cursor_n_s = (cursor == 3'd0) ? LAST_FIELD : cursor - 3'd1;
                    end else begin
                        cursor_n_s = cursor;
                    end
                end
                ST_CLAMP: begin
                    prev_n_s = levels_s;
                    if (val_out[7:0] > dim_s) begin
                        val_n_s[7:0] = dim_s;
                        dirty_n_s    = 1'b1;
                    end else begin
                        val_n_s[7:0] = val_out[7:0];
                    end
                    state_n_s = ST_EDIT;
                end
                default: state_n_s = ST_IDLE;
            endcase
        end
    end

    // State and output registers; ready mirrors "next state is EDIT".
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            prev_r  <= 4'd0;
            val_out <= '0;
            cursor  <= 3'd0;
            dirty   <= 1'b0;
            ready   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            prev_r  <= prev_n_s;
            val_out <= val_n_s;
            cursor  <= cursor_n_s;
            dirty   <= dirty_n_s;
            ready   <= (state_n_s == ST_EDIT);
        end
    end

endmodule

// File: tb/tb_bcd_field_editor.sv
// Randomised plus directed bench for bcd_field_editor (default parameters, date mode).
module tb_bcd_field_editor;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [23:0] val_in;
    logic [3:0]  btn;          // {right, left, down, up}
    logic [23:0] val_out;
    logic [2:0]  cursor;
    logic        dirty, ready;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    bcd_field_editor dut (
        .clk(clk), .reset(reset), .en(en), .val_in(val_in),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
        .val_out(val_out), .cursor(cursor), .dirty(dirty), .ready(ready)
    );

    always #5 clk = ~clk;

    // Behavioural model: fields as decimal integers, phase 0 idle, 1 load, 2 edit, 3 clamp.
    int mv[3];
    int m_cur, m_phase;
    bit m_dirty;
    bit [3:0] m_prev;
    int fmin[3] = '{1, 1, 0};
    int fmax[3] = '{31, 12, 99};

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int mdim(input int m, input int y);
        if (m == 2) return ((2000 + y) % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic model_step();
        bit [3:0] pr;
        int v, nv, lo, hi;
        if (reset) begin
            mv = '{0, 0, 0}; m_cur = 0; m_phase = 0; m_dirty = 0; m_prev = 4'd0;
        end else if (!en) begin
            m_phase = 0; m_cur = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            for (int i = 0; i < 3; i++) mv[i] = from_bcd(val_in[i*8 +: 8]);
            m_dirty = 0; m_cur = 0; m_prev = btn; m_phase = 2;
        end else if (m_phase == 3) begin
            m_prev = btn;
            if (mv[0] > mdim(mv[1], mv[2])) begin
                mv[0] = mdim(mv[1], mv[2]); m_dirty = 1;
            end
            m_phase = 2;
        end else begin
            pr = btn & ~m_prev;
            m_prev = btn;
            v  = mv[m_cur];
            lo = fmin[m_cur];
            hi = (m_cur == 0) ? mdim(mv[1], mv[2]) : fmax[m_cur];
            nv = v;
            if (pr[0] && !pr[1]) nv = (v == hi || v < lo || v > hi) ? lo : v + 1;
            if (pr[1] && !pr[0]) nv = (v == lo || v < lo || v > hi) ? hi : v - 1;
            if (nv != v) begin
                mv[m_cur] = nv; m_dirty = 1;
                if (m_cur != 0) m_phase = 3;
            end
            if (pr[3] && !pr[2]) m_cur = (m_cur + 1) % 3;
            if (pr[2] && !pr[3]) m_cur = (m_cur + 2) % 3;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [23:0] ev;
        if (chk_on) begin
            ev = {to_bcd(mv[2]), to_bcd(mv[1]), to_bcd(mv[0])};
            n_tests++;
            if (val_out !== ev || cursor !== 3'(m_cur) || dirty !== m_dirty || ready !== (m_phase == 2)) begin
                n_fail++;
                $display("FAIL model t=%0t: got val=%h cur=%0d dirty=%b ready=%b, want val=%h cur=%0d dirty=%b ready=%b",
                         $time, val_out, cursor, dirty, ready, ev, m_cur, m_dirty, m_phase == 2);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] b);
        btn = b; cyc();
        btn = 4'd0; cyc();
    endtask

    task automatic reload(input logic [23:0] v);
        en = 1'b0; cyc(); cyc();
        en = 1'b1; val_in = v; cyc(); cyc();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; val_in = 24'h0; btn = 4'd0;
        cyc(); chk_on = 1'b1; cyc();
        chk("reset_val", 32'(val_out), 32'h0);
        chk("reset_flags", {29'd0, cursor[0] | cursor[1] | cursor[2], dirty, ready}, 32'h0);
        reset = 1'b0;

        // Load latency and contents.
        en = 1'b1; val_in = 24'h240228; cyc();
        chk("ready_after_1", 32'(ready), 32'h0);
        cyc();
        chk("ready_after_2", 32'(ready), 32'h1);
        chk("load_val", 32'(val_out), 32'h240228);
        chk("load_dirty", 32'(dirty), 32'h0);

        // Month wrap both ways, then Feb clamp in a common year.
        reload(24'h231231);
        press(4'b1000); chk("cursor_to_month", 32'(cursor), 32'h1);
        press(4'b0001); chk("month_wrap_up", 32'(val_out), 32'h230131);
        chk("dirty_set", 32'(dirty), 32'h1);
        press(4'b0010); chk("month_wrap_down", 32'(val_out), 32'h231231);
        press(4'b0001); press(4'b0001);
        chk("clamp_common", 32'(val_out), 32'h230228);

        // Leap-year clamp.
        reload(24'h240131);
        press(4'b1000); press(4'b0001);
        chk("clamp_leap", 32'(val_out), 32'h240229);

        // Cursor wrap sequence.
        reload(24'h240101);
        for (int i = 0; i < 5; i++) begin
            logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
            press(4'b1000);
            chk("cursor_right", 32'(cursor), 32'(seq[i]));
        end
        press(4'b1000); press(4'b0100);
        chk("cursor_left_wrap", 32'(cursor), 32'h2);

        // BCD carry, simultaneous up/down ignored.
        reload(24'h240109);
        press(4'b0001); chk("bcd_carry", 32'(val_out), 32'h240110);
        press(4'b0011); chk("updown_ignored", 32'(val_out), 32'h240110);

        // Button held across load is not an edge.
        en = 1'b0; cyc(); cyc();
        btn = 4'b0001; en = 1'b1; val_in = 24'h240315; cyc(); cyc(); cyc();
        chk("held_no_edit", 32'(val_out), 32'h240315);
        chk("held_no_dirty", 32'(dirty), 32'h0);
        btn = 4'd0; cyc();

        // en dropped mid-edit.
        press(4'b0001); press(4'b1000);
        en = 1'b0; cyc();
        chk("en_drop_ready", 32'(ready), 32'h0);
        chk("en_drop_cursor", 32'(cursor), 32'h0);
        chk("en_drop_val", 32'(val_out), 32'h240316);
        chk("en_drop_dirty", 32'(dirty), 32'h1);

        // Reset mid-edit.
        en = 1'b1; cyc(); cyc(); press(4'b1000);
        reset = 1'b1; cyc();
        chk("reset_mid_val", 32'(val_out), 32'h0);
        chk("reset_mid_flags", {29'd0, cursor[0] | cursor[1] | cursor[2], dirty, ready}, 32'h0);
        reset = 1'b0;

        // Random traffic checked by the per-cycle model comparison.
        for (int c = 0; c < 6000; c++) begin
            reset = ($urandom_range(0, 999) == 0);
            if (en) en = ($urandom_range(0, 299) != 0);
            else    en = ($urandom_range(0, 3) == 0);
            val_in = {to_bcd($urandom_range(0, 99)), to_bcd($urandom_range(0, 12)),
                      to_bcd($urandom_range(0, 31))};
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) btn[b] = ~btn[b];
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
